// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_pkg
//  Brief    : Shared constants and types for the SISC execution/control core:
//             opcodes, ALU function codes, ALU operation encodings, FSM state
//             encoding and status-register bit positions.
//  Revision : 1.0 - initial release
// ============================================================================
package sisc_pkg;

   // Instruction opcodes (IR[31:28])
   localparam logic [3:0] OP_NOOP = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_BRA  = 4'h4;
   localparam logic [3:0] OP_BRR  = 4'h5;
   localparam logic [3:0] OP_BNE  = 4'h6;
   localparam logic [3:0] OP_BNR  = 4'h7;
   localparam logic [3:0] OP_LOD  = 4'h8;
   localparam logic [3:0] OP_STR  = 4'h9;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Register-ALU function codes (IR[3:0])
   localparam logic [3:0] FUNCT_ADD = 4'h0;
   localparam logic [3:0] FUNCT_SUB = 4'h1;
   localparam logic [3:0] FUNCT_AND = 4'h2;
   localparam logic [3:0] FUNCT_OR  = 4'h3;
   localparam logic [3:0] FUNCT_XOR = 4'h4;
   localparam logic [3:0] FUNCT_NOT = 4'h5;
   localparam logic [3:0] FUNCT_SHL = 4'h6;
   localparam logic [3:0] FUNCT_SHR = 4'h7;

   // ALU operation encodings
   localparam logic [1:0] ALU_OP_REG  = 2'b00;  // RA op RB per FUNCT
   localparam logic [1:0] ALU_OP_IMM  = 2'b01;  // RA + sext(IMM), flags valid
   localparam logic [1:0] ALU_OP_ADDR = 2'b10;  // RA + sext(IMM), address only
   localparam logic [1:0] ALU_OP_PASS = 2'b11;  // pass RB through

   // Status register bit positions within {C,V,N,Z}
   localparam int STAT_C = 3;
   localparam int STAT_V = 2;
   localparam int STAT_N = 1;
   localparam int STAT_Z = 0;

   // Instruction-sequencing states
   typedef enum logic [2:0] {
      ST_START0    = 3'd0,
      ST_START1    = 3'd1,
      ST_FETCH     = 3'd2,
      ST_DECODE    = 3'd3,
      ST_EXECUTE   = 3'd4,
      ST_MEM       = 3'd5,
      ST_WRITEBACK = 3'd6,
      ST_HALT      = 3'd7
   } state_t;

   // True for any of the four conditional branch opcodes
   function automatic logic is_branch(input logic [3:0] opcode);
      return (opcode == OP_BRA) || (opcode == OP_BRR) ||
             (opcode == OP_BNE) || (opcode == OP_BNR);
   endfunction

endpackage : sisc_pkg
`default_nettype wire

// File: rtl/sisc_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_exec_ctrl_if
//  Brief    : Datapath <-> execution/control core bundle. The master modport is
//             the control core (drives strobes, ALU result, branch target);
//             the slave modport is the surrounding datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface sisc_exec_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 16
);
   // Datapath -> core
   logic [DW-1:0] IR;
   logic [DW-1:0] RSA;
   logic [DW-1:0] RSB;
   logic [3:0]    STAT;
   logic [AW-1:0] PC_INC;

   // Core -> datapath
   logic [DW-1:0] ALU_RESULT;
   logic [3:0]    CC;
   logic          CC_EN;
   logic [1:0]    ALU_OP;
   logic [AW-1:0] BR_ADDR;
   logic          BR_SEL;
   logic          RF_WE;
   logic          RD_SEL;
   logic          WB_SEL;
   logic          MM_SEL;
   logic          DM_WE;
   logic          PC_SEL;
   logic          PC_WRITE;
   logic          PC_RST;

   modport master (
      input  IR, RSA, RSB, STAT, PC_INC,
      output ALU_RESULT, CC, CC_EN, ALU_OP, BR_ADDR, BR_SEL, RF_WE, RD_SEL,
             WB_SEL, MM_SEL, DM_WE, PC_SEL, PC_WRITE, PC_RST
   );

   modport slave (
      output IR, RSA, RSB, STAT, PC_INC,
      input  ALU_RESULT, CC, CC_EN, ALU_OP, BR_ADDR, BR_SEL, RF_WE, RD_SEL,
             WB_SEL, MM_SEL, DM_WE, PC_SEL, PC_WRITE, PC_RST
   );

endinterface : sisc_exec_ctrl_if
`default_nettype wire

// File: rtl/sisc_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_alu_core
//  Brief    : Combinational SISC ALU with {C,V,N,Z} status generation.
//             Build option SISC_SHIFT_EN: when defined, FUNCT 6/7 perform
//             logical shift left/right of RA by RB[4:0]; when undefined those
//             codes return 0 and no shifter is built.
//  Revision : 1.0 - initial release
// ============================================================================
module sisc_alu_core
   import sisc_pkg::*;
#(
   parameter int DW = 32
) (
   input  wire logic [1:0]    alu_op,
   input  wire logic [3:0]    funct,
   input  wire logic [DW-1:0] rsa,
   input  wire logic [DW-1:0] rsb,
   input  wire logic [15:0]   imm,
   output logic      [DW-1:0] result,
   output logic      [3:0]    cc
);

   localparam int SHW = $clog2(DW);

   logic [DW-1:0] w_imm_ext;
   logic [DW-1:0] w_add_b;
   logic          w_add_cin;
   logic [DW:0]   w_add_sum;
   logic          w_add_ovf;
   logic          w_arith;

   assign w_imm_ext = {{(DW-16){imm[15]}}, imm};

   // Select the second adder operand; SUB is RA + ~RB + 1 so carry means no-borrow
   always_comb begin
      w_add_b   = rsb;
      w_add_cin = 1'b0;
      case (alu_op)
         ALU_OP_REG: begin
            if (funct == FUNCT_SUB) begin
               w_add_b   = ~rsb;
               w_add_cin = 1'b1;
            end
         end
         ALU_OP_IMM,
         ALU_OP_ADDR: w_add_b = w_imm_ext;
         default:     w_add_b = rsb;
      endcase
   end

   // One shared adder for ADD, SUB, ADDI and address generation
   assign w_add_sum = {1'b0, rsa} + {1'b0, w_add_b} + {{DW{1'b0}}, w_add_cin};
   assign w_add_ovf = (rsa[DW-1] == w_add_b[DW-1]) && (w_add_sum[DW-1] != rsa[DW-1]);

`ifdef SISC_SHIFT_EN
   logic [DW-1:0] w_shl;
   logic [DW-1:0] w_shr;
   assign w_shl = rsa << rsb[SHW-1:0];
   assign w_shr = rsa >> rsb[SHW-1:0];
`endif

   // Result mux; w_arith marks results whose C/V come from the adder
   always_comb begin
      result  = '0;
      w_arith = 1'b0;
      case (alu_op)
         ALU_OP_REG: begin
            case (funct)
               FUNCT_ADD,
               FUNCT_SUB: begin
                  result  = w_add_sum[DW-1:0];
                  w_arith = 1'b1;
               end
               FUNCT_AND: result = rsa & rsb;
               FUNCT_OR:  result = rsa | rsb;
               FUNCT_XOR: result = rsa ^ rsb;
               FUNCT_NOT: result = ~rsa;
`ifdef SISC_SHIFT_EN
               FUNCT_SHL: result = w_shl;
               FUNCT_SHR: result = w_shr;
`endif
               default:   result = '0;
            endcase
         end
         ALU_OP_IMM,
         ALU_OP_ADDR: begin
            result  = w_add_sum[DW-1:0];
            w_arith = 1'b1;
         end
         default: result = rsb;
      endcase
   end

   // Status flags: logic, shift and pass-through clear C and V
   always_comb begin
      cc         = 4'b0000;
      cc[STAT_C] = w_arith ? w_add_sum[DW] : 1'b0;
      cc[STAT_V] = w_arith ? w_add_ovf     : 1'b0;
      cc[STAT_N] = result[DW-1];
      cc[STAT_Z] = (result == '0);
   end

endmodule : sisc_alu_core
`default_nettype wire

// File: rtl/sisc_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_exec_ctrl
//  Brief    : SISC multi-cycle execution/control core: instruction-sequencing
//             FSM, ALU (sisc_alu_core) and branch-target adder. All strobes are
//             decoded combinationally from the current state and IR.
//             Build option SISC_SHIFT_EN enables the ALU shifter.
//  Revision : 1.0 - initial release
// ============================================================================
module sisc_exec_ctrl
   import sisc_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 16
) (
   input  wire logic          CLK,
   input  wire logic          RST_F,
   sisc_exec_ctrl_if.master   bus
);

   state_t        r_state;
   state_t        w_next_state;

   logic [3:0]    w_opcode;
   logic [3:0]    w_mm;
   logic [15:0]   w_imm;
   logic [3:0]    w_funct;
   logic          w_unused_ir;

   logic          w_is_mem;
   logic          w_br_abs;
   logic          w_br_cond;
   logic          w_br_taken;
   logic [1:0]    w_op_alu_op;
   logic [AW-1:0] w_br_rel;

   logic          w_cc_en;
   logic [1:0]    w_alu_op;
   logic          w_br_sel;
   logic          w_rf_we;
   logic          w_rd_sel;
   logic          w_wb_sel;
   logic          w_mm_sel;
   logic          w_dm_we;
   logic          w_pc_sel;
   logic          w_pc_write;
   logic          w_pc_rst;

   // IR field extraction; RA/RB index the register file outside this block
   assign w_opcode    = bus.IR[31:28];
   assign w_mm        = bus.IR[27:24];
   assign w_imm       = bus.IR[15:0];
   assign w_funct     = bus.IR[3:0];
   assign w_unused_ir = ^bus.IR[23:16];

   // Instruction-class decode
   assign w_is_mem   = (w_opcode == OP_LOD) || (w_opcode == OP_STR);
   assign w_br_abs   = (w_opcode == OP_BRA) || (w_opcode == OP_BNE);
   assign w_br_cond  = |(bus.STAT & w_mm);
   assign w_br_taken = ((w_opcode == OP_BRA) || (w_opcode == OP_BRR)) ?  w_br_cond :
                       ((w_opcode == OP_BNE) || (w_opcode == OP_BNR)) ? !w_br_cond :
                       1'b0;
   assign w_op_alu_op = (w_opcode == OP_ADDI) ? ALU_OP_IMM  :
                        w_is_mem              ? ALU_OP_ADDR :
                                                ALU_OP_REG;

   // Branch-target adder: relative targets wrap modulo 2^AW
   assign w_br_rel    = bus.PC_INC + AW'(w_imm);
   assign bus.BR_ADDR = w_br_abs ? AW'(w_imm) : w_br_rel;

   // State register; reset abandons any instruction in flight
   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         r_state <= ST_START0;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: fixed five-cycle instruction loop, HLT parks in HALT
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_START0:    w_next_state = ST_START1;
         ST_START1:    w_next_state = ST_FETCH;
         ST_FETCH:     w_next_state = ST_DECODE;
         ST_DECODE:    w_next_state = (w_opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE:   w_next_state = ST_MEM;
         ST_MEM:       w_next_state = ST_WRITEBACK;
         ST_WRITEBACK: w_next_state = ST_FETCH;
         ST_HALT:      w_next_state = ST_HALT;
         default:      w_next_state = ST_START0;
      endcase
   end

   // Output decode: every strobe defaults low outside the state that uses it
   always_comb begin
      w_cc_en    = 1'b0;
      w_alu_op   = ALU_OP_REG;
      w_br_sel   = 1'b0;
      w_rf_we    = 1'b0;
      w_rd_sel   = 1'b0;
      w_wb_sel   = 1'b0;
      w_mm_sel   = 1'b0;
      w_dm_we    = 1'b0;
      w_pc_sel   = 1'b0;
      w_pc_write = 1'b0;
      w_pc_rst   = 1'b0;
      case (r_state)
         ST_START0: begin
            w_pc_rst = 1'b1;
         end
         ST_FETCH: begin
            w_pc_write = 1'b1;
            w_pc_sel   = 1'b0;
         end
         ST_DECODE: begin
            if (is_branch(w_opcode)) begin
               w_br_sel = w_br_abs;
               if (w_br_taken) begin
                  w_pc_write = 1'b1;
                  w_pc_sel   = 1'b1;
               end
            end
         end
         ST_EXECUTE: begin
            w_alu_op = w_op_alu_op;
            w_cc_en  = (w_opcode == OP_ALU) || (w_opcode == OP_ADDI);
            w_mm_sel = w_is_mem && (w_mm != 4'h0);
         end
         ST_MEM: begin
            w_alu_op = w_op_alu_op;
            w_mm_sel = w_is_mem && (w_mm != 4'h0);
            w_dm_we  = (w_opcode == OP_STR);
         end
         ST_WRITEBACK: begin
            w_alu_op = w_op_alu_op;
            w_mm_sel = w_is_mem && (w_mm != 4'h0);
            case (w_opcode)
               OP_ALU: begin
                  w_rf_we  = 1'b1;
                  w_wb_sel = 1'b1;
                  w_rd_sel = 1'b0;
               end
               OP_ADDI: begin
                  w_rf_we  = 1'b1;
                  w_wb_sel = 1'b1;
                  w_rd_sel = 1'b1;
               end
               OP_LOD: begin
                  w_rf_we  = 1'b1;
                  w_wb_sel = 1'b0;
                  w_rd_sel = 1'b1;
               end
               default: w_rf_we = 1'b0;
            endcase
         end
         default: w_pc_rst = 1'b0;
      endcase
   end

   assign bus.CC_EN    = w_cc_en;
   assign bus.ALU_OP   = w_alu_op;
   assign bus.BR_SEL   = w_br_sel;
   assign bus.RF_WE    = w_rf_we;
   assign bus.RD_SEL   = w_rd_sel;
   assign bus.WB_SEL   = w_wb_sel;
   assign bus.MM_SEL   = w_mm_sel;
   assign bus.DM_WE    = w_dm_we;
   assign bus.PC_SEL   = w_pc_sel;
   assign bus.PC_WRITE = w_pc_write;
   assign bus.PC_RST   = w_pc_rst;

   sisc_alu_core #(
      .DW (DW)
   ) u_alu (
      .alu_op (w_alu_op),
      .funct  (w_funct),
      .rsa    (bus.RSA),
      .rsb    (bus.RSB),
      .imm    (w_imm),
      .result (bus.ALU_RESULT),
      .cc     (bus.CC)
   );

endmodule : sisc_exec_ctrl
`default_nettype wire

// File: tb/tb_sisc_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sisc_exec_ctrl
//  Brief    : Directed self-checking bench for sisc_exec_ctrl. Strobes are
//             packed as {CC_EN, ALU_OP[1:0], BR_SEL, RF_WE, RD_SEL, WB_SEL,
//             MM_SEL, DM_WE, PC_SEL, PC_WRITE, PC_RST}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sisc_exec_ctrl;

   logic clk;
   logic rst_f;
   int   n_checks;
   int   n_errors;

   sisc_exec_ctrl_if #(.DW(32), .AW(16)) bus ();

   sisc_exec_ctrl #(
      .DW (32),
      .AW (16)
   ) dut (
      .CLK   (clk),
      .RST_F (rst_f),
      .bus   (bus.master)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] strobes();
      return {bus.CC_EN, bus.ALU_OP, bus.BR_SEL, bus.RF_WE, bus.RD_SEL,
              bus.WB_SEL, bus.MM_SEL, bus.DM_WE, bus.PC_SEL, bus.PC_WRITE,
              bus.PC_RST};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one state and settle past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_f     = 1'b0;
      bus.IR     = 32'h0;
      bus.RSA    = 32'h0;
      bus.RSB    = 32'h0;
      bus.STAT   = 4'h0;
      bus.PC_INC = 16'h0;

      // Reset state and start-up sequence
      #2;
      check("reset_strobes", {20'h0, strobes()}, 32'h001);
      @(negedge clk);
      rst_f = 1'b1;
      #1;
      check("start0", {20'h0, strobes()}, 32'h001);
      step();
      check("start1", {20'h0, strobes()}, 32'h000);
      step();
      check("fetch0", {20'h0, strobes()}, 32'h002);

      // ADD 7FFFFFFF + 1
      bus.IR  = 32'h10123000;
      bus.RSA = 32'h7FFFFFFF;
      bus.RSB = 32'h00000001;
      step();
      check("add_decode", {20'h0, strobes()}, 32'h000);
      step();
      check("add_exec", {20'h0, strobes()}, 32'h800);
      check("add_result", bus.ALU_RESULT, 32'h80000000);
      check("add_cc", {28'h0, bus.CC}, 32'h6);
      step();
      check("add_mem", {20'h0, strobes()}, 32'h000);
      step();
      check("add_wb", {20'h0, strobes()}, 32'h0A0);
      step();
      check("fetch1", {20'h0, strobes()}, 32'h002);

      // SUB 5 - 5
      bus.IR  = 32'h10123001;
      bus.RSA = 32'h5;
      bus.RSB = 32'h5;
      step();
      step();
      check("sub_exec", {20'h0, strobes()}, 32'h800);
      check("sub_result", bus.ALU_RESULT, 32'h0);
      check("sub_cc", {28'h0, bus.CC}, 32'h9);
      step();
      step();
      check("sub_wb", {20'h0, strobes()}, 32'h0A0);
      step();

      // ADDI 0x10 + sext(FFFF)
      bus.IR  = 32'h2012FFFF;
      bus.RSA = 32'h10;
      step();
      step();
      check("addi_exec", {20'h0, strobes()}, 32'hA00);
      check("addi_result", bus.ALU_RESULT, 32'h0000000F);
      check("addi_cc", {28'h0, bus.CC}, 32'h8);
      step();
      check("addi_mem", {20'h0, strobes()}, 32'h200);
      step();
      check("addi_wb", {20'h0, strobes()}, 32'h2E0);
      step();

      // BRR taken: 0x0010 + 0xFFFE
      bus.IR     = 32'h5100FFFE;
      bus.STAT   = 4'h1;
      bus.PC_INC = 16'h0010;
      step();
      check("brr_taken_decode", {20'h0, strobes()}, 32'h006);
      check("brr_addr", {16'h0, bus.BR_ADDR}, 32'h000E);
      step();
      check("brr_exec", {20'h0, strobes()}, 32'h000);
      step();
      step();
      check("brr_wb", {20'h0, strobes()}, 32'h000);
      step();

      // BRR not taken
      bus.STAT = 4'h0;
      step();
      check("brr_nt_decode", {20'h0, strobes()}, 32'h000);
      check("brr_nt_addr", {16'h0, bus.BR_ADDR}, 32'h000E);
      step();
      step();
      step();
      step();

      // BNE with MM=0: always taken, absolute target
      bus.IR   = 32'h60001234;
      bus.STAT = 4'hF;
      step();
      check("bne_decode", {20'h0, strobes()}, 32'h106);
      check("bne_addr", {16'h0, bus.BR_ADDR}, 32'h1234);
      step();
      step();
      step();
      step();

      // STR, MM=0: address RA + IMM
      bus.IR  = 32'h90120002;
      bus.RSA = 32'h4;
      step();
      check("str_decode", {20'h0, strobes()}, 32'h000);
      step();
      check("str_exec", {20'h0, strobes()}, 32'h400);
      check("str_result", bus.ALU_RESULT, 32'h6);
      step();
      check("str_mem", {20'h0, strobes()}, 32'h408);
      step();
      check("str_wb", {20'h0, strobes()}, 32'h400);
      step();

      // LOD, MM=1: absolute address, load into IR[19:16]
      bus.IR = 32'h81120040;
      step();
      step();
      check("lod_exec", {20'h0, strobes()}, 32'h410);
      check("lod_result", bus.ALU_RESULT, 32'h44);
      step();
      check("lod_mem", {20'h0, strobes()}, 32'h410);
      step();
      check("lod_wb", {20'h0, strobes()}, 32'h4D0);
      step();

      // SHL 3 by 4 (build-dependent)
      bus.IR  = 32'h10123006;
      bus.RSA = 32'h3;
      bus.RSB = 32'h4;
      step();
      step();
`ifdef SISC_SHIFT_EN
      check("shl_result", bus.ALU_RESULT, 32'h30);
      check("shl_cc", {28'h0, bus.CC}, 32'h0);
`else
      check("shl_result", bus.ALU_RESULT, 32'h0);
      check("shl_cc", {28'h0, bus.CC}, 32'h1);
`endif
      step();
      step();
      step();

      // Reset asserted mid-EXECUTE
      bus.IR  = 32'h10123000;
      bus.RSA = 32'h1;
      bus.RSB = 32'h2;
      step();
      step();
      check("pre_reset_exec", {20'h0, strobes()}, 32'h800);
      rst_f = 1'b0;
      #1;
      check("mid_reset_strobes", {20'h0, strobes()}, 32'h001);
      step();
      check("held_reset_strobes", {20'h0, strobes()}, 32'h001);
      @(negedge clk);
      rst_f = 1'b1;
      #1;
      check("rel_start0", {20'h0, strobes()}, 32'h001);
      step();
      check("rel_start1", {20'h0, strobes()}, 32'h000);
      step();
      check("rel_fetch", {20'h0, strobes()}, 32'h002);

      // HLT parks the core
      bus.IR = 32'hF0000000;
      step();
      check("hlt_decode", {20'h0, strobes()}, 32'h000);
      for (int i = 0; i < 10; i++) begin
         step();
         check("halt_hold", {20'h0, strobes()}, 32'h000);
      end
      bus.IR = 32'h10123000;
      step();
      check("halt_ignores_ir", {20'h0, strobes()}, 32'h000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sisc_exec_ctrl
`default_nettype wire
